rf_wb_sched: RTL and testbench
==============================

// Module: rf_wb_sched
// PURPOSE
//  Scheduler for the single RF write port (RFWr/A3/WD). Two writers share it: the in-order
//  pipeline writeback (WB) and the multi-cycle mul/div unit (MDU), whose results are buffered.
//  Also holds a 32-bit pending scoreboard of MDU destinations for decode-stage hazard checks.
//  Sits between the WB stage, the MDU and the RF instance in the CPU top.
// PARAMETERS
//  DEPTH      2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_MAX 4   consecutive WB grants with FIFO non-empty before the FIFO is forced through
// PORTS
//  clk          in   1   rising-edge clock
//  rstn         in   1   asynchronous active-low reset
//  wb_vld       in   1   WB write request
//  wb_addr      in   5   WB destination register
//  wb_data      in   32  WB write data
//  wb_rdy       out  1   WB write accepted this cycle (low => pipeline holds WB)
//  mdu_iss      in   1   MDU op issued; marks mdu_iss_rd pending
//  mdu_iss_rd   in   5   destination of issued MDU op
//  mdu_iss_rdy  out  1   issue allowed (mdu_iss_rd not already pending)
//  mdu_vld      in   1   MDU result valid
//  mdu_addr     in   5   MDU result destination
//  mdu_data     in   32  MDU result data
//  mdu_rdy      out  1   FIFO not full
//  rs_addr      in   5   decode source A
//  rt_addr      in   5   decode source B
//  hz           out  1   rs or rt (non-zero) is pending => decode stalls
//  rf_wr        out  1   to RF RFWr
//  rf_a3        out  5   to RF A3
//  rf_wd        out  32  to RF WD
// BEHAVIOUR
//  - Reset: FIFO empty, pending=0, starve_cnt=0 => mdu_rdy=1, hz=0, rf_wr=wb_vld, wb_rdy=1.
//  - MDU push when mdu_vld&&mdu_rdy; mdu_rdy=!full (registered count, no same-cycle pop credit).
//    Minimum latency of an MDU result to the RF: 1 cycle (no bypass around the FIFO).
//  - Grant (combinational): force = !empty && starve_cnt==STARVE_MAX.
//    force          -> FIFO head to RF, pop, wb_rdy=0.
//    else wb_vld    -> WB to RF, wb_rdy=1.
//    else !empty    -> FIFO head to RF, pop.
//    else rf_wr=0; rf_a3/rf_wd=0.
//  - starve_cnt: +1 on a WB grant while FIFO non-empty (saturates at STARVE_MAX).
//    Cleared on any FIFO pop or when the FIFO is empty.
//  - Address 0: the grant/pop/ack happens, but rf_wr=0 (the write is dropped).
//  - Scoreboard: a granted MDU pop clears pending[addr] on the same edge. An accepted issue
//    (mdu_iss && mdu_iss_rdy && rd!=0) sets pending[rd]. If a set and a clear hit the same bit
//    in one cycle, the set wins. An issue with rd==0 sets nothing.
//  - mdu_iss_rdy = !pending[mdu_iss_rd]. WAW is prevented by the issuer.
//  - hz = (rs_addr!=0 && pending[rs_addr]) || (rt_addr!=0 && pending[rt_addr]); combinational.
//  - FIFO wrap: pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare.
//  - Reset mid-operation: buffered results and pending bits are discarded. The MDU is reset
//    by the same rstn.
// STRUCTURE
//  - Shared package/header cpu_defs: REG_AW=5, XLEN=32, REG_ZERO=5'd0.
//  - One sub-module: wb_fifo (DEPTH x {addr,data}, push/pop/full/empty/head).
//  - Arbiter, starve counter and scoreboard live in this module.
// TESTING
//  1 Reset, wb_vld=1 addr=3 data=0x11 -> rf_wr=1 A3=3 WD=0x11, wb_rdy=1, hz=0.
//  2 Issue rd=5; rs_addr=5 -> hz=1. mdu_vld addr=5 data=0xCAFE with WB idle -> rf_wr=1 next
//    cycle, WD=0xCAFE, pending[5] clears, hz=0 the following cycle.
//  3 FIFO holds 1 entry, wb_vld held high for 6 cycles -> WB granted 4 cycles, 5th cycle FIFO
//    forced with wb_rdy=0, 6th cycle WB again.
//  4 Push 3 results while WB is busy every cycle -> mdu_rdy=0 after 2; third held until a pop;
//    FIFO order preserved.
//  5 Pending bit clears on pop of rd=7 while a new issue rd=7 arrives -> pending[7]=1 and
//    mdu_iss_rdy=0 the next cycle. Issue rd=0 -> hz stays 0.
//  6 rstn low with 2 buffered results and 2 pending bits -> async clear: mdu_rdy=1, hz=0,
//    no rf_wr after release.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_sched_pkg
//   Shared CPU-level constants (register address width, data width, the zero
//   register) plus the types used by the RF write-port scheduler.
//   No ports: package only.
// ---------------------------------------------------------------------------
package rf_wb_sched_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREG   = 1 << REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One buffered RF write: destination register plus data.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_req_t;

  // Which writer owns the RF write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_FIFO = 2'd2
  } grant_sel_t;

endpackage

// File: rtl/rf_wb_sched_if.sv
// ---------------------------------------------------------------------------
// rf_wb_sched_if
//   Bundles every non-clock signal between the write-port scheduler and its
//   neighbours (WB stage, MDU issue/result, decode hazard lookup, RF port).
//   master : the CPU side driving requests and consuming acks / RF write.
//   slave  : the scheduler itself.
//   Signals:
//     wb_vld/wb_addr/wb_data, wb_rdy            WB write request / accept
//     mdu_iss/mdu_iss_rd, mdu_iss_rdy           MDU issue, marks rd pending
//     mdu_vld/mdu_addr/mdu_data, mdu_rdy        MDU result push / FIFO space
//     rs_addr/rt_addr, hz                       decode sources / stall
//     rf_wr/rf_a3/rf_wd                         RF write port
// ---------------------------------------------------------------------------
interface rf_wb_sched_if;
  import rf_wb_sched_pkg::*;

  logic              wb_vld;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              wb_rdy;

  logic              mdu_iss;
  logic [REG_AW-1:0] mdu_iss_rd;
  logic              mdu_iss_rdy;

  logic              mdu_vld;
  logic [REG_AW-1:0] mdu_addr;
  logic [XLEN-1:0]   mdu_data;
  logic              mdu_rdy;

  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic              hz;

  logic              rf_wr;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd;

  modport master (
    output wb_vld, wb_addr, wb_data,
    output mdu_iss, mdu_iss_rd,
    output mdu_vld, mdu_addr, mdu_data,
    output rs_addr, rt_addr,
    input  wb_rdy, mdu_iss_rdy, mdu_rdy, hz,
    input  rf_wr, rf_a3, rf_wd
  );

  modport slave (
    input  wb_vld, wb_addr, wb_data,
    input  mdu_iss, mdu_iss_rd,
    input  mdu_vld, mdu_addr, mdu_data,
    input  rs_addr, rt_addr,
    output wb_rdy, mdu_iss_rdy, mdu_rdy, hz,
    output rf_wr, rf_a3, rf_wd
  );

endinterface

// File: rtl/rf_wb_sched_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small FIFO holding MDU results until the RF write port is free.
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset
//     i_push         write i_pushEntry (ignored when full)
//     i_pushEntry    {addr, data} to store
//     i_pop          drop the head entry (ignored when empty)
//     o_full/o_empty occupancy flags, derived from registered pointers
//     o_head         oldest entry, valid when !o_empty
// ---------------------------------------------------------------------------
module wb_fifo
  import rf_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    i_push,
  input  wr_req_t i_pushEntry,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output wr_req_t o_head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  wr_req_t     r_mem [DEPTH];

  logic w_doPush;
  logic w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_pushEntry;
  end

endmodule

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched
//   Owns the single RF write port. The in-order WB stage normally wins; MDU
//   results are buffered in wb_fifo and drained when WB is idle, or forced
//   through after STARVE_MAX consecutive WB grants while results wait.
//   Also keeps a pending bit per register for in-flight MDU destinations,
//   used for decode hazard detection and to gate new MDU issues.
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset
//     bus         rf_wb_sched_if.slave (WB, MDU, decode and RF signals)
// ---------------------------------------------------------------------------
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  rf_wb_sched_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     r_starveCnt;
  logic [NREG-1:0]   r_pending;

  logic              w_full;
  logic              w_empty;
  wr_req_t           w_head;
  wr_req_t           w_pushEntry;
  logic              w_push;
  logic              w_pop;
  logic              w_force;
  grant_sel_t        w_sel;
  logic              w_granted;
  logic [REG_AW-1:0] w_wrAddr;
  logic [XLEN-1:0]   w_wrData;
  logic              w_issRdy;
  logic              w_issAcc;
  logic [NREG-1:0]   w_setMask;
  logic [NREG-1:0]   w_clrMask;

  assign w_pushEntry = '{addr: bus.mdu_addr, data: bus.mdu_data};
  assign w_push      = bus.mdu_vld && !w_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_pushEntry (w_pushEntry),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // MDU results never bypass the FIFO, so space is judged on the registered
  // count only; a pop in the same cycle does not free a slot early.
  assign bus.mdu_rdy = !w_full;

  assign w_force = !w_empty && (r_starveCnt == STARVE_LIM);

  always_comb begin
    w_sel = GNT_NONE;
    if (w_force)          w_sel = GNT_FIFO;
    else if (bus.wb_vld)  w_sel = GNT_WB;
    else if (!w_empty)    w_sel = GNT_FIFO;
  end

  assign w_pop      = (w_sel == GNT_FIFO);
  assign bus.wb_rdy = !w_force;

  always_comb begin
    w_granted = 1'b0;
    w_wrAddr  = '0;
    w_wrData  = '0;
    case (w_sel)
      GNT_WB: begin
        w_granted = 1'b1;
        w_wrAddr  = bus.wb_addr;
        w_wrData  = bus.wb_data;
      end
      GNT_FIFO: begin
        w_granted = 1'b1;
        w_wrAddr  = w_head.addr;
        w_wrData  = w_head.data;
      end
      default: ;
    endcase
  end

  // A write to r0 still consumes the grant but never reaches the RF.
  assign bus.rf_wr = w_granted && (w_wrAddr != REG_ZERO);
  assign bus.rf_a3 = w_wrAddr;
  assign bus.rf_wd = w_wrData;

  // Counts how long buffered results have been waiting behind WB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starveCnt <= '0;
    end else if (w_empty || w_pop) begin
      r_starveCnt <= '0;
    end else if ((w_sel == GNT_WB) && (r_starveCnt != STARVE_LIM)) begin
      r_starveCnt <= r_starveCnt + SW'(1);
    end
  end

  assign w_issRdy        = !r_pending[bus.mdu_iss_rd];
  assign bus.mdu_iss_rdy = w_issRdy;
  assign w_issAcc        = bus.mdu_iss && w_issRdy && (bus.mdu_iss_rd != REG_ZERO);

  assign w_setMask = w_issAcc ? (NREG'(1) << bus.mdu_iss_rd) : '0;
  assign w_clrMask = (w_pop && (w_head.addr != REG_ZERO)) ? (NREG'(1) << w_head.addr) : '0;

  // Set is applied after clear so a new issue to the register being retired
  // in the same cycle stays pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clrMask) | w_setMask;
    end
  end

  assign bus.hz = ((bus.rs_addr != REG_ZERO) && r_pending[bus.rs_addr]) ||
                  ((bus.rt_addr != REG_ZERO) && r_pending[bus.rt_addr]);

endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];

  rf_wb_sched_if bus();

  rf_wb_sched #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleInputs();
    bus.wb_vld     = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus.mdu_iss    = 1'b0;
    bus.mdu_iss_rd = '0;
    bus.mdu_vld    = 1'b0;
    bus.mdu_addr   = '0;
    bus.mdu_data   = '0;
    bus.rs_addr    = '0;
    bus.rt_addr    = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idleInputs();
    bus.wb_vld  = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'h11;
    @(negedge clk);
    checks++;
    if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd3, 32'h11}) begin
      failures++;
      $display("[TB] FAIL reset_wb_write: got wr=%b a3=%0d wd=%h, required wr=1 a3=3 wd=11",
               bus.rf_wr, bus.rf_a3, bus.rf_wd);
    end
    checks++;
    if ({bus.wb_rdy, bus.hz, bus.mdu_rdy, bus.mdu_iss_rdy} !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL reset_flags: got wb_rdy=%b hz=%b mdu_rdy=%b iss_rdy=%b, required 1 0 1 1",
               bus.wb_rdy, bus.hz, bus.mdu_rdy, bus.mdu_iss_rdy);
    end
    nextCycle();
    rstn = 1'b1;
    idleInputs();
  endtask

  task automatic test_mdu_path();
    exp_t e;
    nextCycle();
    idleInputs();
    bus.mdu_iss    = 1'b1;
    bus.mdu_iss_rd = 5'd5;
    bus.rs_addr    = 5'd5;
    @(negedge clk);
    checks++;
    if ({bus.mdu_iss_rdy, bus.hz} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL issue_rd5: got iss_rdy=%b hz=%b, required 1 0", bus.mdu_iss_rdy, bus.hz);
    end

    nextCycle();
    idleInputs();
    bus.rs_addr    = 5'd5;
    bus.mdu_iss_rd = 5'd5;
    bus.mdu_vld    = 1'b1;
    bus.mdu_addr   = 5'd5;
    bus.mdu_data   = 32'hCAFE;
    @(negedge clk);
    checks++;
    if ({bus.hz, bus.mdu_iss_rdy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL pending_rd5: got hz=%b iss_rdy=%b, required 1 0", bus.hz, bus.mdu_iss_rdy);
    end
    checks++;
    if ({bus.mdu_rdy, bus.rf_wr} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mdu_push_no_bypass: got mdu_rdy=%b rf_wr=%b, required 1 0", bus.mdu_rdy, bus.rf_wr);
    end
    pushExp(5'd5, 32'hCAFE);

    nextCycle();
    idleInputs();
    bus.rs_addr = 5'd5;
    @(negedge clk);
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL mdu_drain: scoreboard empty, got wr=%b a3=%0d", bus.rf_wr, bus.rf_a3);
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== e.addr || bus.rf_wd !== e.data) begin
        failures++;
        $display("[TB] FAIL mdu_drain: got wr=%b a3=%0d wd=%h, required wr=1 a3=%0d wd=%h",
                 bus.rf_wr, bus.rf_a3, bus.rf_wd, e.addr, e.data);
      end
    end
    checks++;
    if (bus.hz !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hz_before_clear: got %b, required 1", bus.hz);
    end

    nextCycle();
    idleInputs();
    bus.rs_addr = 5'd5;
    @(negedge clk);
    checks++;
    if ({bus.hz, bus.rf_wr} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL hz_after_clear: got hz=%b rf_wr=%b, required 0 0", bus.hz, bus.rf_wr);
    end
  endtask

  task automatic test_starve();
    exp_t        e;
    logic [31:0] expData;
    nextCycle();
    idleInputs();
    bus.wb_vld   = 1'b1;
    bus.wb_addr  = 5'd1;
    bus.wb_data  = 32'h100;
    bus.mdu_vld  = 1'b1;
    bus.mdu_addr = 5'd9;
    bus.mdu_data = 32'h900;
    @(negedge clk);
    checks++;
    if ({bus.rf_wr, bus.rf_a3, bus.mdu_rdy} !== {1'b1, 5'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL starve_setup: got wr=%b a3=%0d mdu_rdy=%b, required 1 1 1",
               bus.rf_wr, bus.rf_a3, bus.mdu_rdy);
    end
    pushExp(5'd9, 32'h900);

    for (int i = 1; i <= 6; i++) begin
      nextCycle();
      idleInputs();
      expData     = 32'h200 + 32'(i);
      bus.wb_vld  = 1'b1;
      bus.wb_addr = 5'd2;
      bus.wb_data = expData;
      @(negedge clk);
      if (i == 5) begin
        checks++;
        if (bus.wb_rdy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL starve_force_wbrdy: cycle %0d got wb_rdy=%b, required 0", i, bus.wb_rdy);
        end
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL starve_force: scoreboard empty, got a3=%0d", bus.rf_a3);
        end else begin
          e = expQ.pop_front();
          checks++;
          if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== e.addr || bus.rf_wd !== e.data) begin
            failures++;
            $display("[TB] FAIL starve_force: got wr=%b a3=%0d wd=%h, required wr=1 a3=%0d wd=%h",
                     bus.rf_wr, bus.rf_a3, bus.rf_wd, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if ({bus.wb_rdy, bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 1'b1, 5'd2, expData}) begin
          failures++;
          $display("[TB] FAIL starve_wb_grant: cycle %0d got wb_rdy=%b wr=%b a3=%0d wd=%h, required 1 1 2 %h",
                   i, bus.wb_rdy, bus.rf_wr, bus.rf_a3, bus.rf_wd, expData);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    exp_t        e;
    logic        expRdy;
    logic [31:0] expData;
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      idleInputs();
      expData     = 32'h400 + 32'(c);
      bus.wb_vld  = 1'b1;
      bus.wb_addr = 5'd4;
      bus.wb_data = expData;
      bus.mdu_vld = 1'b1;
      if (c == 1) begin
        bus.mdu_addr = 5'd10;
        bus.mdu_data = 32'hA0;
      end else if (c == 2) begin
        bus.mdu_addr = 5'd11;
        bus.mdu_data = 32'hA1;
      end else begin
        bus.mdu_addr = 5'd12;
        bus.mdu_data = 32'hA2;
      end
      expRdy = (c <= 2) || (c == 7);
      @(negedge clk);
      checks++;
      if (bus.mdu_rdy !== expRdy) begin
        failures++;
        $display("[TB] FAIL full_mdu_rdy: cycle %0d got %b, required %b", c, bus.mdu_rdy, expRdy);
      end
      if (expRdy) pushExp(bus.mdu_addr, bus.mdu_data);
      if (c == 6) begin
        checks++;
        if (bus.wb_rdy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL full_force_wbrdy: got wb_rdy=%b, required 0", bus.wb_rdy);
        end
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL full_force: scoreboard empty, got a3=%0d", bus.rf_a3);
        end else begin
          e = expQ.pop_front();
          checks++;
          if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== e.addr || bus.rf_wd !== e.data) begin
            failures++;
            $display("[TB] FAIL full_force: got wr=%b a3=%0d wd=%h, required wr=1 a3=%0d wd=%h",
                     bus.rf_wr, bus.rf_a3, bus.rf_wd, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if ({bus.wb_rdy, bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 1'b1, 5'd4, expData}) begin
          failures++;
          $display("[TB] FAIL full_wb_grant: cycle %0d got wb_rdy=%b wr=%b a3=%0d wd=%h, required 1 1 4 %h",
                   c, bus.wb_rdy, bus.rf_wr, bus.rf_a3, bus.rf_wd, expData);
        end
      end
    end

    for (int c = 0; c < 3; c++) begin
      nextCycle();
      idleInputs();
      @(negedge clk);
      if (c < 2) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL full_drain: scoreboard empty, got a3=%0d", bus.rf_a3);
        end else begin
          e = expQ.pop_front();
          checks++;
          if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== e.addr || bus.rf_wd !== e.data) begin
            failures++;
            $display("[TB] FAIL full_drain: got wr=%b a3=%0d wd=%h, required wr=1 a3=%0d wd=%h",
                     bus.rf_wr, bus.rf_a3, bus.rf_wd, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if (bus.rf_wr !== 1'b0 || expQ.size() != 0) begin
          failures++;
          $display("[TB] FAIL full_drained: got rf_wr=%b queued=%0d, required 0 0", bus.rf_wr, expQ.size());
        end
      end
    end
  endtask

  task automatic test_pending_race();
    exp_t e;
    nextCycle();
    idleInputs();
    bus.mdu_vld  = 1'b1;
    bus.mdu_addr = 5'd7;
    bus.mdu_data = 32'h777;
    @(negedge clk);
    checks++;
    if ({bus.mdu_rdy, bus.rf_wr} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL race_push: got mdu_rdy=%b rf_wr=%b, required 1 0", bus.mdu_rdy, bus.rf_wr);
    end
    pushExp(5'd7, 32'h777);

    nextCycle();
    idleInputs();
    bus.mdu_iss    = 1'b1;
    bus.mdu_iss_rd = 5'd7;
    bus.rs_addr    = 5'd7;
    @(negedge clk);
    checks++;
    if ({bus.mdu_iss_rdy, bus.hz} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL race_issue: got iss_rdy=%b hz=%b, required 1 0", bus.mdu_iss_rdy, bus.hz);
    end
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL race_pop: scoreboard empty, got a3=%0d", bus.rf_a3);
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== e.addr || bus.rf_wd !== e.data) begin
        failures++;
        $display("[TB] FAIL race_pop: got wr=%b a3=%0d wd=%h, required wr=1 a3=%0d wd=%h",
                 bus.rf_wr, bus.rf_a3, bus.rf_wd, e.addr, e.data);
      end
    end

    nextCycle();
    idleInputs();
    bus.mdu_iss_rd = 5'd7;
    bus.rt_addr    = 5'd7;
    @(negedge clk);
    checks++;
    if ({bus.mdu_iss_rdy, bus.hz} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL race_set_wins: got iss_rdy=%b hz=%b, required 0 1", bus.mdu_iss_rdy, bus.hz);
    end

    nextCycle();
    idleInputs();
    bus.mdu_iss    = 1'b1;
    bus.mdu_iss_rd = 5'd0;
    @(negedge clk);
    checks++;
    if (bus.mdu_iss_rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL issue_r0: got iss_rdy=%b, required 1", bus.mdu_iss_rdy);
    end

    nextCycle();
    idleInputs();
    bus.mdu_iss_rd = 5'd0;
    @(negedge clk);
    checks++;
    if ({bus.mdu_iss_rdy, bus.hz} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL r0_not_pending: got iss_rdy=%b hz=%b, required 1 0", bus.mdu_iss_rdy, bus.hz);
    end
  endtask

  task automatic test_async_reset();
    nextCycle();
    idleInputs();
    bus.wb_vld     = 1'b1;
    bus.wb_addr    = 5'd4;
    bus.wb_data    = 32'h44;
    bus.mdu_iss    = 1'b1;
    bus.mdu_iss_rd = 5'd12;
    bus.mdu_vld    = 1'b1;
    bus.mdu_addr   = 5'd20;
    bus.mdu_data   = 32'h2020;
    @(negedge clk);
    checks++;
    if ({bus.mdu_rdy, bus.mdu_iss_rdy} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL arst_fill1: got mdu_rdy=%b iss_rdy=%b, required 1 1", bus.mdu_rdy, bus.mdu_iss_rdy);
    end
    pushExp(5'd20, 32'h2020);

    nextCycle();
    idleInputs();
    bus.wb_vld     = 1'b1;
    bus.wb_addr    = 5'd4;
    bus.wb_data    = 32'h45;
    bus.mdu_iss    = 1'b1;
    bus.mdu_iss_rd = 5'd13;
    bus.mdu_vld    = 1'b1;
    bus.mdu_addr   = 5'd21;
    bus.mdu_data   = 32'h2121;
    @(negedge clk);
    checks++;
    if (bus.mdu_rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_fill2: got mdu_rdy=%b, required 1", bus.mdu_rdy);
    end
    pushExp(5'd21, 32'h2121);

    nextCycle();
    idleInputs();
    bus.rs_addr = 5'd12;
    bus.rt_addr = 5'd13;
    @(negedge clk);
    checks++;
    if ({bus.mdu_rdy, bus.hz} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL arst_before: got mdu_rdy=%b hz=%b, required 0 1", bus.mdu_rdy, bus.hz);
    end

    #2;
    rstn = 1'b0;
    expQ.delete();
    bus.mdu_iss_rd = 5'd7;
    #1;
    checks++;
    if ({bus.mdu_rdy, bus.hz, bus.rf_wr, bus.mdu_iss_rdy} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL arst_async_clear: got mdu_rdy=%b hz=%b rf_wr=%b iss_rdy=%b, required 1 0 0 1",
               bus.mdu_rdy, bus.hz, bus.rf_wr, bus.mdu_iss_rdy);
    end

    nextCycle();
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      idleInputs();
      bus.rs_addr = 5'd12;
      bus.rt_addr = 5'd13;
      @(negedge clk);
      checks++;
      if ({bus.rf_wr, bus.hz, bus.mdu_rdy} !== 3'b001) begin
        failures++;
        $display("[TB] FAIL arst_after: cycle %0d got rf_wr=%b hz=%b mdu_rdy=%b, required 0 0 1",
                 c, bus.rf_wr, bus.hz, bus.mdu_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mdu_path();
    test_starve();
    test_fifo_full();
    test_pending_race();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
